// File: rtl/rf_pkg.sv
// Shared register-file writeback widths and the queued write entry type.
package rf_pkg;

    localparam int unsigned RF_A_WIDTH = 5;
    localparam int unsigned RF_D_WIDTH = 32;

    typedef struct packed {
        logic [RF_A_WIDTH-1:0] rd;
        logic [RF_D_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue: up to two ordered writes and one head read per cycle.
// Exposes raw storage, per-slot valid bits and the head pointer for hazard matching.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr0_en,
    input  wb_entry_t                   wr0_data,
    input  logic                        wr1_en,
    input  wb_entry_t                   wr1_data,
    input  logic                        rd_en,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]            valid,
    output logic [$clog2(DEPTH)-1:0]    head_ptr,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;

    // wr1 is only ever used together with wr0, so it lands one slot behind it
    assign wr_ptr_nxt = wr_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries  <= '0;
            valid    <= '0;
            wr_ptr   <= '0;
            head_ptr <= '0;
            count    <= '0;
        end else begin
            if (rd_en) begin
                valid[head_ptr] <= 1'b0;
                head_ptr        <= head_ptr + PTR_W'(1);
            end
            if (wr0_en) begin
                entries[wr_ptr] <= wr0_data;
                valid[wr_ptr]   <= 1'b1;
            end
            if (wr1_en) begin
                entries[wr_ptr_nxt] <= wr1_data;
                valid[wr_ptr_nxt]   <= 1'b1;
            end
            wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            count  <= count + OCC_W'(wr0_en) + OCC_W'(wr1_en) - OCC_W'(rd_en);
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and load results into one register-file write port through a small queue.
// Optional RF_WRITEBACK_FWD_EN adds q1_fwd/q2_fwd carrying the youngest pending data.
module rf_writeback
    import rf_pkg::*;
#(
    parameter int unsigned A_WIDTH = RF_A_WIDTH,
    parameter int unsigned D_WIDTH = RF_D_WIDTH,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [A_WIDTH-1:0]       alu_rd,
    input  logic [D_WIDTH-1:0]       alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [A_WIDTH-1:0]       mem_rd,
    input  logic [D_WIDTH-1:0]       mem_data,
    output logic                     mem_ready,
    output logic                     WE3,
    output logic [A_WIDTH-1:0]       AD3,
    output logic [D_WIDTH-1:0]       WD3,
    input  logic [A_WIDTH-1:0]       q1_rd,
    input  logic [A_WIDTH-1:0]       q2_rd,
    output logic                     q1_busy,
    output logic                     q2_busy,
`ifdef RF_WRITEBACK_FWD_EN
    output logic [D_WIDTH-1:0]       q1_fwd,
    output logic [D_WIDTH-1:0]       q2_fwd,
`endif
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      head_ptr;
    logic [OCC_W-1:0]      free;
    wb_entry_t             head;
    wb_entry_t             mem_entry;
    wb_entry_t             alu_entry;
    wb_entry_t             wr0_data;
    logic                  acc_mem;
    logic                  acc_alu;
    logic                  store_mem;
    logic                  store_alu;
    logic                  wr0_en;
    logic                  wr1_en;
    logic                  rd_en;
    logic [PTR_W-1:0]      slot;
    logic                  q1_hit;
    logic                  q2_hit;
`ifdef RF_WRITEBACK_FWD_EN
    logic [D_WIDTH-1:0]    q1_sel;
    logic [D_WIDTH-1:0]    q2_sel;
`endif

    // Source handshakes; mem gets first claim on the last free slot
    assign free      = OCC_W'(DEPTH) - occ;
    assign mem_ready = rst_n && (free != '0);
    assign alu_ready = rst_n && ((free >= OCC_W'(2)) || ((free == OCC_W'(1)) && !mem_valid));
    assign acc_mem   = mem_valid && mem_ready;
    assign acc_alu   = alu_valid && alu_ready;

    // x0 writes complete the handshake but are never stored
    assign store_mem = acc_mem && (mem_rd != '0);
    assign store_alu = acc_alu && (alu_rd != '0);

    assign mem_entry = '{rd: RF_A_WIDTH'(mem_rd), data: RF_D_WIDTH'(mem_data)};
    assign alu_entry = '{rd: RF_A_WIDTH'(alu_rd), data: RF_D_WIDTH'(alu_data)};
    assign wr0_en    = store_mem || store_alu;
    assign wr0_data  = store_mem ? mem_entry : alu_entry;
    assign wr1_en    = store_mem && store_alu;
    assign rd_en     = (occ != '0);
    assign head      = entries[head_ptr];

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (alu_entry),
        .rd_en    (rd_en),
        .entries  (entries),
        .valid    (valid),
        .head_ptr (head_ptr),
        .count    (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3 <= 1'b0;
            AD3 <= '0;
            WD3 <= '0;
        end else begin
            WE3 <= rd_en;
            if (rd_en) begin
                AD3 <= A_WIDTH'(head.rd);
                WD3 <= D_WIDTH'(head.data);
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest pending value
    always_comb begin
        slot   = '0;
        q1_hit = WE3 && (AD3 == q1_rd);
        q2_hit = WE3 && (AD3 == q2_rd);
`ifdef RF_WRITEBACK_FWD_EN
        q1_sel = WD3;
        q2_sel = WD3;
`endif
        for (int k = 0; k < int'(DEPTH); k++) begin
            slot = head_ptr + PTR_W'(k);
            if (valid[slot] && (A_WIDTH'(entries[slot].rd) == q1_rd)) begin
                q1_hit = 1'b1;
`ifdef RF_WRITEBACK_FWD_EN
                q1_sel = D_WIDTH'(entries[slot].data);
`endif
            end
            if (valid[slot] && (A_WIDTH'(entries[slot].rd) == q2_rd)) begin
                q2_hit = 1'b1;
`ifdef RF_WRITEBACK_FWD_EN
                q2_sel = D_WIDTH'(entries[slot].data);
`endif
            end
        end
    end

    assign q1_busy = rst_n && (q1_rd != '0) && q1_hit;
    assign q2_busy = rst_n && (q2_rd != '0) && q2_hit;

`ifdef RF_WRITEBACK_FWD_EN
    assign q1_fwd = q1_busy ? q1_sel : '0;
    assign q2_fwd = q2_busy ? q2_sel : '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed vector table, reset corner case, random run vs queue model.
module tb_rf_writeback;

    localparam int DEPTH = 4;
    localparam int NVEC  = 19;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic [4:0]  q1_rd;
    logic [4:0]  q2_rd;
    logic        q1_busy;
    logic        q2_busy;
`ifdef RF_WRITEBACK_FWD_EN
    logic [31:0] q1_fwd;
    logic [31:0] q2_fwd;
`endif
    logic [2:0]  occ;

    rf_writeback #(
        .A_WIDTH (5),
        .D_WIDTH (32),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .WE3       (WE3),
        .AD3       (AD3),
        .WD3       (WD3),
        .q1_rd     (q1_rd),
        .q2_rd     (q2_rd),
        .q1_busy   (q1_busy),
        .q2_busy   (q2_busy),
`ifdef RF_WRITEBACK_FWD_EN
        .q1_fwd    (q1_fwd),
        .q2_fwd    (q2_fwd),
`endif
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic [4:0] r1, input logic [4:0] r2);
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        q1_rd     = r1;  q2_rd  = r2;
    endtask

    // Directed vectors: pre-edge handshake/hazard outputs, post-edge write port and occupancy
    typedef struct {
        logic        mv;   logic [4:0] mrd;  logic [31:0] mdat;
        logic        av;   logic [4:0] ard;  logic [31:0] adat;
        logic [4:0]  q1;   logic [4:0] q2;
        logic        e_mr; logic       e_ar; logic e_b1; logic e_b2; logic [31:0] e_f1;
        logic        e_we; logic [4:0] e_ad; logic [31:0] e_wd; logic [2:0] e_occ;
    } vec_t;

    vec_t vecs [NVEC];

    // Reference model: pending writes in order, plus the last write-port state
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_ad;
    logic [31:0] m_wd;

    function automatic logic m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return m_we && (m_ad == r);
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] r);
        if (!m_busy(r)) return 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == r) return mq[i].data;
        return m_wd;
    endfunction

    initial begin
        //           mv mrd mdat       av ard adat          q1 q2  mr ar b1 b2 f1             we ad wd             occ
        vecs[0]  = '{0, 0,  0,         0, 0,  0,            0, 0,  1, 1, 0, 0, 0,            0, 0, 0,            0};
        vecs[1]  = '{0, 0,  0,         1, 5,  32'hDEADBEEF, 5, 0,  1, 1, 0, 0, 0,            0, 0, 0,            1};
        vecs[2]  = '{0, 0,  0,         0, 0,  0,            5, 6,  1, 1, 1, 0, 32'hDEADBEEF, 1, 5, 32'hDEADBEEF, 0};
        vecs[3]  = '{0, 0,  0,         0, 0,  0,            5, 5,  1, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0,            0};
        vecs[4]  = '{0, 0,  0,         1, 0,  32'h55,       0, 5,  1, 1, 0, 0, 0,            0, 0, 0,            0};
        vecs[5]  = '{0, 0,  0,         0, 0,  0,            5, 0,  1, 1, 0, 0, 0,            0, 0, 0,            0};
        vecs[6]  = '{1, 3,  32'h11,    1, 4,  32'h22,       3, 4,  1, 1, 0, 0, 0,            0, 0, 0,            2};
        vecs[7]  = '{0, 0,  0,         0, 0,  0,            4, 3,  1, 1, 1, 1, 32'h22,       1, 3, 32'h11,       1};
        vecs[8]  = '{0, 0,  0,         0, 0,  0,            4, 3,  1, 1, 1, 1, 32'h22,       1, 4, 32'h22,       0};
        vecs[9]  = '{0, 0,  0,         0, 0,  0,            4, 3,  1, 1, 1, 0, 32'h22,       0, 0, 0,            0};
        vecs[10] = '{1, 7,  32'h70,    1, 7,  32'h71,       7, 0,  1, 1, 0, 0, 0,            0, 0, 0,            2};
        vecs[11] = '{0, 0,  0,         0, 0,  0,            7, 0,  1, 1, 1, 0, 32'h71,       1, 7, 32'h70,       1};
        vecs[12] = '{0, 0,  0,         0, 0,  0,            7, 0,  1, 1, 1, 0, 32'h71,       1, 7, 32'h71,       0};
        vecs[13] = '{0, 0,  0,         0, 0,  0,            7, 0,  1, 1, 1, 0, 32'h71,       0, 0, 0,            0};
        vecs[14] = '{0, 0,  0,         0, 0,  0,            7, 0,  1, 1, 0, 0, 0,            0, 0, 0,            0};
        vecs[15] = '{1, 1,  32'hA1,    1, 2,  32'hA2,       0, 0,  1, 1, 0, 0, 0,            0, 0, 0,            2};
        vecs[16] = '{1, 6,  32'hA6,    1, 8,  32'hA8,       0, 0,  1, 1, 0, 0, 0,            1, 1, 32'hA1,       3};
        vecs[17] = '{1, 9,  32'hA9,    1, 10, 32'hAA,       0, 0,  1, 0, 0, 0, 0,            1, 2, 32'hA2,       3};
        vecs[18] = '{0, 0,  0,         1, 10, 32'hAA,      10, 9,  1, 1, 0, 1, 0,            1, 6, 32'hA6,       3};

        // Reset state
        rst_n = 1'b0;
        apply(1, 3, 32'h1, 1, 4, 32'h2, 3, 4);
        #1;
        check("rst alu_ready", 64'(alu_ready), 64'(0));
        check("rst mem_ready", 64'(mem_ready), 64'(0));
        check("rst WE3", 64'(WE3), 64'(0));
        check("rst occ", 64'(occ), 64'(0));
        check("rst q1_busy", 64'(q1_busy), 64'(0));
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].mv, vecs[i].mrd, vecs[i].mdat, vecs[i].av, vecs[i].ard, vecs[i].adat,
                  vecs[i].q1, vecs[i].q2);
            #1;
            check($sformatf("v%0d mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
            check($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
            check($sformatf("v%0d q1_busy", i), 64'(q1_busy), 64'(vecs[i].e_b1));
            check($sformatf("v%0d q2_busy", i), 64'(q2_busy), 64'(vecs[i].e_b2));
`ifdef RF_WRITEBACK_FWD_EN
            check($sformatf("v%0d q1_fwd", i), 64'(q1_fwd), 64'(vecs[i].e_f1));
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d WE3", i), 64'(WE3), 64'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check($sformatf("v%0d AD3", i), 64'(AD3), 64'(vecs[i].e_ad));
                check($sformatf("v%0d WD3", i), 64'(WD3), 64'(vecs[i].e_wd));
            end
            check($sformatf("v%0d occ", i), 64'(occ), 64'(vecs[i].e_occ));
        end

        // Reset mid-cycle with three writes pending: everything clears at once, nothing drains
        apply(1, 11, 32'hB1, 1, 12, 32'hB2, 8, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst WE3", 64'(WE3), 64'(0));
        check("arst occ", 64'(occ), 64'(0));
        check("arst AD3", 64'(AD3), 64'(0));
        check("arst WD3", 64'(WD3), 64'(0));
        check("arst mem_ready", 64'(mem_ready), 64'(0));
        check("arst alu_ready", 64'(alu_ready), 64'(0));
        check("arst q1_busy", 64'(q1_busy), 64'(0));
        check("arst q2_busy", 64'(q2_busy), 64'(0));
        apply(0, 0, 0, 0, 0, 0, 8, 9);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst mem_ready", 64'(mem_ready), 64'(1));
        check("post-rst alu_ready", 64'(alu_ready), 64'(1));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-rst WE3 c%0d", c), 64'(WE3), 64'(0));
            check($sformatf("post-rst occ c%0d", c), 64'(occ), 64'(0));
        end

        // Random traffic against the queue model, starting from the empty post-reset state
        m_we = 1'b0;
        m_ad = '0;
        m_wd = '0;
        mq.delete();
        for (int n = 0; n < 1500; n++) begin
            logic        mv, av, exp_mr, exp_ar;
            logic [4:0]  mrd, ard, r1, r2;
            logic [31:0] mdat, adat;
            int          fr;
            ent_t        e;
            mv   = ($urandom_range(0, 3) != 0);
            av   = ($urandom_range(0, 3) != 0);
            mrd  = 5'($urandom_range(0, 7));
            ard  = 5'($urandom_range(0, 7));
            r1   = 5'($urandom_range(0, 7));
            r2   = 5'($urandom_range(0, 7));
            mdat = $urandom;
            adat = $urandom;
            apply(mv, mrd, mdat, av, ard, adat, r1, r2);
            #1;
            fr     = DEPTH - mq.size();
            exp_mr = (fr >= 1);
            exp_ar = (fr >= 2) || (fr == 1 && !mv);
            check("rand mem_ready", 64'(mem_ready), 64'(exp_mr));
            check("rand alu_ready", 64'(alu_ready), 64'(exp_ar));
            check("rand q1_busy", 64'(q1_busy), 64'(m_busy(r1)));
            check("rand q2_busy", 64'(q2_busy), 64'(m_busy(r2)));
`ifdef RF_WRITEBACK_FWD_EN
            check("rand q1_fwd", 64'(q1_fwd), 64'(m_fwd(r1)));
            check("rand q2_fwd", 64'(q2_fwd), 64'(m_fwd(r2)));
`endif
            if (mq.size() > 0) begin
                e    = mq.pop_front();
                m_we = 1'b1;
                m_ad = e.rd;
                m_wd = e.data;
            end else begin
                m_we = 1'b0;
            end
            if (mv && exp_mr && mrd != 5'd0) mq.push_back('{mrd, mdat});
            if (av && exp_ar && ard != 5'd0) mq.push_back('{ard, adat});
            @(posedge clk);
            #1;
            check("rand WE3", 64'(WE3), 64'(m_we));
            if (m_we) begin
                check("rand AD3", 64'(AD3), 64'(m_ad));
                check("rand WD3", 64'(WD3), 64'(m_wd));
            end
            check("rand occ", 64'(occ), 64'(mq.size()));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL have parameter A_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter D_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter DEPTH, default 4, write-queue entries, power of 2, minimum 2.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (clock, rising edge); rst_n input 1 (asynchronous reset, active low).
REQ-005 SHALL have ports alu_valid in 1, alu_rd in A_WIDTH, alu_data in D_WIDTH, alu_ready out 1 (ALU result source).
REQ-006 SHALL have ports mem_valid in 1, mem_rd in A_WIDTH, mem_data in D_WIDTH, mem_ready out 1 (load-unit result source).
REQ-007 SHALL have ports WE3 out 1, AD3 out A_WIDTH, WD3 out D_WIDTH, driving the register-file write port.
REQ-008 SHALL have ports q1_rd in A_WIDTH, q2_rd in A_WIDTH, q1_busy out 1, q2_busy out 1 (hazard query).
REQ-009 SHALL have port occ out $clog2(DEPTH)+1, the current queue occupancy.

Function
REQ-010 SHALL accept a source beat when valid && ready are both high at a rising clk edge.
REQ-011 SHALL set mem_ready = (free >= 1), where free = DEPTH - occ.
REQ-012 SHALL set alu_ready = (free >= 2) || (free == 1 && !mem_valid); mem has priority.
REQ-013 SHALL enqueue mem before alu when both are accepted in the same cycle, preserving that order at drain.
REQ-014 SHALL discard beats with rd == 0 at acceptance: the handshake completes, nothing is stored, and x0 is never written.
REQ-015 SHALL dequeue the head entry every cycle the queue is non-empty.
REQ-016 SHALL register the dequeued entry onto WE3=1, AD3=rd, WD3=data on the next clk edge; WE3=0 when nothing is dequeued.
REQ-017 SHALL give a latency of one cycle from acceptance to WE3 for an empty queue; otherwise queue position + 1.
REQ-018 SHALL allow simultaneous enqueue(s) and dequeue in one cycle, with occ updated by +accepted-stored minus dequeued.
REQ-019 SHALL wrap the read/write pointers modulo DEPTH; the full (occ==DEPTH) and empty (occ==0) states SHALL be unambiguous.
REQ-020 SHALL assert qN_busy combinationally when qN_rd != 0 and qN_rd matches any valid queue entry or the currently asserted AD3 (WE3=1).
REQ-021 SHALL drive qN_busy=0 for qN_rd == 0.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear occ, both pointers, WE3, AD3 and WD3 to 0; all queued writes are dropped.
REQ-023 SHALL, during reset, drive alu_ready=0, mem_ready=0 and q1_busy=q2_busy=0.
REQ-024 SHALL resume normal operation with free=DEPTH at the first clk edge after rst_n is deasserted.

Configuration
REQ-025 SHALL, with macro RF_WRITEBACK_FWD_EN defined, add ports q1_fwd out D_WIDTH and q2_fwd out D_WIDTH carrying the data of the youngest match (queue tail-side first, then WD3); the value is 0 when not busy.
REQ-026 SHALL, without RF_WRITEBACK_FWD_EN, omit those ports and the data-select logic; busy behaviour is unchanged.

Structure
REQ-027 SHALL take A_WIDTH/D_WIDTH defaults and typedef wb_entry_t {rd, data} from shared package rf_pkg.
REQ-028 SHALL implement the queue as sub-module wb_fifo (two ordered writes, one read per cycle), exposing entry array and valid bits for the match logic.

Verification
REQ-029 SHALL verify: alu x5=0xDEADBEEF into empty queue -> next cycle WE3=1, AD3=5, WD3=0xDEADBEEF; following cycle WE3=0.
REQ-030 SHALL verify: same-cycle mem x3=0x11, alu x4=0x22, empty queue -> WE3 writes x3 at cycle+1, then x4 at cycle+2.
REQ-031 SHALL verify: alu rd=0 data 0x55 -> alu_ready=1, occ stays 0, WE3 never asserted.
REQ-032 SHALL verify: occ=DEPTH-1 with both valid -> mem accepted, alu_ready=0; alu accepted the next cycle.
REQ-033 SHALL verify: x7 queued, q1_rd=7 -> q1_busy=1 until the cycle after WE3 for x7; with FWD_EN, q1_fwd equals the youngest x7 data.
REQ-034 SHALL verify: rst_n pulsed low with occ=3 -> WE3=0 and occ=0 immediately; no queued write reaches the register file.
